// File: rtl/serial_sum_collector.sv
// rtl/serial_sum_collector.sv - reassembles LSB-first serial adder words with carry-out into a show-ahead FIFO
module serial_sum_collector #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ser_sum,
    input  logic                         ser_ovf,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_word,
    output logic                         out_ovf,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         drop_err,
    output logic [CNT_W-1:0]             drop_cnt
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {S_UNPRIMED, S_COLLECT} state_t;

    state_t             r_state;
    logic [IW-1:0]      r_bit_idx;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_held;
    logic               r_pending;
    logic [WIDTH:0]     r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_level;
    logic               r_drop_err;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_collect;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_accept;
    logic               w_drop;
    logic [WIDTH-1:0]   w_word_done;

    assign w_collect = (r_state == S_COLLECT);
    assign w_last    = (r_bit_idx == IW'(WIDTH - 1));
    // The carry-out of the held word rides on the next word's bit-0 slot.
    assign w_push    = w_collect && (r_bit_idx == '0) && r_pending;
    assign w_pop     = (r_level != '0) && out_ready;
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_accept  = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    always_comb begin
        w_word_done            = r_shift;
        w_word_done[r_bit_idx] = ser_sum;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_UNPRIMED;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_held     <= '0;
            r_pending  <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop_err <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                S_UNPRIMED: r_state <= S_COLLECT;
                S_COLLECT: begin
                    r_shift   <= w_word_done;
                    r_bit_idx <= w_last ? '0 : r_bit_idx + IW'(1);
                    if (w_last) begin
                        r_held    <= w_word_done;
                        r_pending <= 1'b1;
                    end
                end
                default: r_state <= S_UNPRIMED;
            endcase

            if (w_accept) begin
                r_mem[r_wr_ptr] <= {ser_ovf, r_held};
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (w_drop) begin
                r_drop_err <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = (r_level != '0);
    assign out_word  = out_valid ? r_mem[r_rd_ptr][WIDTH-1:0] : '0;
    assign out_ovf   = out_valid ? r_mem[r_rd_ptr][WIDTH] : 1'b0;
    assign level     = r_level;
    assign drop_err  = r_drop_err;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: doc/serial_sum_collector.md
Name: serial_sum_collector

Overview:
Downstream consumer of the 4-bit LSB-first serial adder FSM. Samples the adder's registered sum bit and end-of-word overflow flag every clock. Reassembles each word and attaches its carry-out, which arrives one bit-slot late on the next word's bit 0. Buffers completed words in a small show-ahead FIFO with a valid/ready handshake to the parallel side.

Parameters:
WIDTH, 4, bits per serial word; must equal the adder word length (4)
DEPTH, 4, FIFO entries (≥2, power of two)
CNT_W, 8, width of saturating drop counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high; shared with the adder
ser_sum  input  1  adder sum bit, registered, valid from 2nd post-reset edge
ser_ovf  input  1  adder overflow flag; meaningful only on bit-0 slots
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head this cycle
out_word  output  WIDTH  head sum word, bit 0 = first serial bit
out_ovf  output  1  head word carry-out
level  output  $clog2(DEPTH+1)  FIFO occupancy
drop_err  output  1  sticky: a completed word was lost to FIFO full
drop_cnt  output  CNT_W  number of dropped words, saturates at all-ones

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock.
- Reset (clock edge with reset=1): all outputs 0, FIFO empty, bit_idx=0, primed=0, pending=0, partial word cleared. Partial words are not counted as drops.
- Priming: the adder outputs reset values at the first edge with reset=0. At that edge, set primed=1 and sample nothing. Sampling starts at the next edge and continues every edge after that; there is no bubble or stall input.
- FSM states:
  - UNPRIMED -> COLLECT on the first non-reset edge.
  - COLLECT stays in COLLECT.
  - Any state -> UNPRIMED on reset.
- In COLLECT, each edge:
  - shift[bit_idx] <= ser_sum
  - bit_idx <= (bit_idx == WIDTH-1) ? 0 : bit_idx+1
- Bit-0 slot (bit_idx==0):
  - If pending=1, push {ser_ovf, held_word} into the FIFO.
  - ser_ovf in the first bit-0 slot after reset is ignored.
- Last slot (bit_idx==WIDTH-1): copy the completed word to held_word and set pending=1.
  - pending stays 1 afterwards; every later bit-0 slot pushes.
- Latency: the last bit is sampled at edge N. The push happens at edge N+1. If the FIFO was empty, out_valid=1 after edge N+1.
- FIFO:
  - Show-ahead: out_word and out_ovf reflect the head whenever out_valid=1.
  - Pop when out_valid & out_ready.
  - Push and pop in the same edge: level unchanged, both succeed, including when full (pop frees the slot).
  - out_ready while empty has no effect.
  - Pointers wrap modulo DEPTH.
- Overflow: push while level==DEPTH with no simultaneous pop:
  - word discarded
  - drop_err <= 1 (sticky until reset)
  - drop_cnt increments, saturating at 2^CNT_W-1
  - FIFO contents untouched
- Reset mid-word or mid-FIFO: everything discarded. Alignment restarts with a fresh priming edge, matching the adder restarting at its initial state.
- out_word/out_ovf are don't-care when out_valid=0 (bench must not check them).

Test Plan:
1. Basic word: reset, then priming edge. Drive ser_sum = 0,0,0,1 on samples 1-4, then sample 5 ser_sum=x, ser_ovf=0. After sample 5: out_valid=1, out_word=4'h8, out_ovf=0, level=1.
2. Carry-out: word samples 1,0,1,0, then bit-0 slot with ser_ovf=1. Result: out_word=4'h5, out_ovf=1. A ser_ovf=1 on the very first bit-0 slot after reset produces no push and no effect.
3. Full FIFO: out_ready=0, stream 6 words (5 pushes). Result: level=4, words 1-4 intact in order, 5th dropped, drop_err=1, drop_cnt=1.
4. Full plus pop: FIFO full with out_ready=1 on the push edge. Result: push accepted, level stays 4, drop_cnt unchanged, head advances to word 2.
5. Reset mid-word: assert reset after 2 bits sampled with 2 words queued. Result: out_valid=0, level=0, drop_err=0, drop_cnt=0. After release, one priming edge then a new word; first output word = 4 bits sampled after priming.
6. Saturation: CNT_W=2, force 5 drops. Result: drop_cnt=3 and holds, drop_err=1.
